stream_matrix_loader: RTL and testbench

- Accepts a serial stream of WIDTH-bit scalars (IEEE-754 single precision in the system) over a valid/ready handshake.
- Writes the scalars in row-major order into a NUM_ROWS x NUM_COLS matrix storage block through that block's single-element write port.
- After the last element it signals completion with a one-cycle pulse, then re-arms for the next matrix.
- Sits between the AXI-stream-style input adapter and the matrix storage.

---
 rtl/stream_matrix_loader.sv | 109 ++++++++++
 tb/tb_stream_matrix_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_matrix_loader.sv
// Streams WIDTH-bit scalars into a NUM_ROWS x NUM_COLS matrix in row-major order,
// then pulses finished_loading once per matrix and re-arms for the next one.
// Latency: 1 cycle from accept to write strobe; finished_loading follows the last strobe by 1 cycle.
// Backpressure: ds_next_data is high in LOAD and low for the single DONE cycle (and during reset).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ds_out, ds_valid, ds_next_data input stream (data, valid, ready)
//   write_row_addr, write_col_addr matrix write address
//   write_data, write_ready        matrix write data and strobe
//   finished_loading               one-cycle pulse after the last element of a matrix is written
module stream_matrix_loader #(
  parameter  int NUM_ROWS       = 4,
  parameter  int NUM_COLS       = 5,
  parameter  int WIDTH          = 32,
  localparam int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int COL_ADDR_WIDTH = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          ds_out,
  input  logic                      ds_valid,
  output logic                      ds_next_data,
  output logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
  output logic [COL_ADDR_WIDTH-1:0] write_col_addr,
  output logic [WIDTH-1:0]          write_data,
  output logic                      write_ready,
  output logic                      finished_loading
);

  localparam logic [ROW_ADDR_WIDTH-1:0] ROW_LAST = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [COL_ADDR_WIDTH-1:0] COL_LAST = COL_ADDR_WIDTH'(NUM_COLS - 1);

  typedef enum logic {LOAD, DONE} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [ROW_ADDR_WIDTH-1:0]   row_cnt;
  logic [COL_ADDR_WIDTH-1:0]   col_cnt;
  logic                        accept;
  logic                        last_elem;

  // Ready comes from state only, so there is no combinational path from ds_valid.
  assign accept    = (state == LOAD) && ds_valid;
  assign last_elem = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ds_next_data = 1'b0;
    case (state)
      LOAD: begin
        ds_next_data = 1'b1;
        if (ds_valid && last_elem) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = LOAD;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
    if (rst) begin
      ds_next_data = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt          <= '0;
      col_cnt          <= '0;
      write_row_addr   <= '0;
      write_col_addr   <= '0;
      write_data       <= '0;
      write_ready      <= 1'b0;
      finished_loading <= 1'b0;
    end else begin
      write_ready <= accept;
      // The DONE cycle carries the final strobe; its closing edge commits that
      // write, so the completion pulse appears in the cycle that follows.
      finished_loading <= (state == DONE);
      if (accept) begin
        write_data     <= ds_out;
        write_row_addr <= row_cnt;
        write_col_addr <= col_cnt;
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          if (row_cnt == ROW_LAST) begin
            row_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_matrix_loader.sv
module tb_stream_matrix_loader;

  localparam int NR = 4;
  localparam int NC = 5;
  localparam int NE = NR * NC;

  logic        clk;
  logic        rst;
  logic [31:0] ds_out;
  logic        ds_valid;
  logic        ds_next_data;
  logic [1:0]  write_row_addr;
  logic [2:0]  write_col_addr;
  logic [31:0] write_data;
  logic        write_ready;
  logic        finished_loading;

  stream_matrix_loader #(.NUM_ROWS(NR), .NUM_COLS(NC), .WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .ds_out           (ds_out),
    .ds_valid         (ds_valid),
    .ds_next_data     (ds_next_data),
    .write_row_addr   (write_row_addr),
    .write_col_addr   (write_col_addr),
    .write_data       (write_data),
    .write_ready      (write_ready),
    .finished_loading (finished_loading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  row;
    logic [2:0]  col;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [NR][NC];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_wr_cyc = -10;
  int          fin_cnt = 0;
  int          exp_fin = 0;
  int          wr_cnt = 0;
  int          run = 0;
  int          max_run = 0;
  int          nrdy = 0;
  int          m_row = 0;
  int          m_col = 0;

  // IEEE-754 single-precision bits of a nonzero integer.
  function automatic logic [31:0] fbits(int n);
    int a;
    int e;
    a = (n < 0) ? -n : n;
    e = 0;
    while ((a >> (e + 1)) != 0) e++;
    return {(n < 0), 8'(127 + e), 23'((a - (1 << e)) << (23 - e))};
  endfunction

  function automatic int val(int set, int k);
    if (set == 0) return k + 1;
    if (set == 1) return -(k + 1);
    return 21 + k;
  endfunction

  // Monitor: scoreboard on write strobes, pulse timing, stall accounting.
  always @(negedge clk) begin
    wr_t e;
    cyc = cyc + 1;
    if (rst === 1'b0 && ds_next_data === 1'b0) nrdy = nrdy + 1;
    if (finished_loading === 1'b1) begin
      fin_cnt = fin_cnt + 1;
      total = total + 1;
      if (cyc !== last_wr_cyc + 1) begin
        bad = bad + 1;
        $display("FAIL fin_timing: pulse at cycle %0d, last strobe at cycle %0d (want +1)", cyc, last_wr_cyc);
      end
    end
    if (write_ready === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      run = run + 1;
      if (run > max_run) max_run = run;
      last_wr_cyc = cyc;
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_write: got (%0d,%0d)=%h with nothing pending", write_row_addr, write_col_addr, write_data);
      end else begin
        e = exp_q.pop_front();
        if (write_row_addr !== e.row || write_col_addr !== e.col || write_data !== e.data) begin
          bad = bad + 1;
          $display("FAIL write: got (%0d,%0d)=%h want (%0d,%0d)=%h", write_row_addr, write_col_addr, write_data, e.row, e.col, e.data);
        end
      end
      if (write_row_addr < NR && write_col_addr < NC) mem[write_row_addr][write_col_addr] = write_data;
    end else begin
      run = 0;
    end
  end

  task automatic send(input logic [31:0] v, input int gap);
    wr_t e;
    bit  acc;
    int  guard;
    ds_out   = v;
    ds_valid = 1'b1;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      if (ds_next_data === 1'b1) begin
        e.row  = 2'(m_row);
        e.col  = 3'(m_col);
        e.data = v;
        exp_q.push_back(e);
        acc = 1'b1;
        if (m_col == NC - 1) begin
          m_col = 0;
          if (m_row == NR - 1) begin
            m_row = 0;
            exp_fin = exp_fin + 1;
          end else begin
            m_row = m_row + 1;
          end
        end else begin
          m_col = m_col + 1;
        end
      end
      guard = guard + 1;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL send_timeout: ready=%b after %0d cycles, want 1", ds_next_data, guard);
    end
    if (gap > 0) begin
      ds_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    ds_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    ds_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic check_mem(input int set, input string name);
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        total = total + 1;
        if (mem[r][c] !== fbits(val(set, r * NC + c))) begin
          bad = bad + 1;
          $display("FAIL %s mem(%0d,%0d): got %h want %h", name, r, c, mem[r][c], fbits(val(set, r * NC + c)));
        end
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    ds_valid = 1'b1;
    ds_out   = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total = total + 1;
    if (ds_next_data !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_ready: got %b want 0", ds_next_data);
    end
    total = total + 1;
    if (write_ready !== 1'b0 || finished_loading !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_strobes: write_ready=%b finished=%b want 0 0", write_ready, finished_loading);
    end
    total = total + 1;
    if (write_row_addr !== 2'd0 || write_col_addr !== 3'd0 || write_data !== 32'd0) begin
      bad = bad + 1;
      $display("FAIL reset_outputs: row=%0d col=%0d data=%h want 0 0 0", write_row_addr, write_col_addr, write_data);
    end
    ds_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int f0;
    f0 = fin_cnt;
    max_run = 0;
    nrdy = 0;
    wr_cnt = 0;
    for (int k = 0; k < NE; k++) send(fbits(val(0, k)), 0);
    idle(4);
    check_int("single_writes", wr_cnt, NE);
    check_int("single_run", max_run, NE);
    check_int("single_fin", fin_cnt - f0, 1);
    check_int("single_stalls", nrdy, 1);
    total = total + 1;
    if (mem[3][4] !== 32'h41A0_0000) begin
      bad = bad + 1;
      $display("FAIL single_last: got %h want 41a00000", mem[3][4]);
    end
    check_mem(0, "single");
  endtask

  task automatic test_gapped();
    int f0;
    f0 = fin_cnt;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) mem[r][c] = 32'h0;
    max_run = 0;
    wr_cnt = 0;
    for (int k = 0; k < NE; k++) begin
      send(fbits(val(0, k)), 2);
      if (k == NE - 2) check_int("gapped_no_early_fin", fin_cnt - f0, 0);
    end
    idle(4);
    check_int("gapped_writes", wr_cnt, NE);
    check_int("gapped_run", max_run, 1);
    check_int("gapped_fin", fin_cnt - f0, 1);
    check_mem(0, "gapped");
  endtask

  task automatic test_two_matrices();
    int f0;
    f0 = fin_cnt;
    nrdy = 0;
    for (int k = 0; k < NE; k++) send(fbits(val(0, k)), 0);
    idle(6);
    check_mem(0, "two_first");
    for (int k = 0; k < NE; k++) send(fbits(val(1, k)), (k % 3 == 0) ? 1 : 0);
    idle(4);
    check_int("two_fin", fin_cnt - f0, 2);
    check_int("two_stalls", nrdy, 2);
    check_mem(1, "two_second");
  endtask

  task automatic test_done_valid();
    for (int k = 0; k < NE; k++) send(fbits(val(0, k)), 0);
    // Now inside the DONE cycle, the last strobe is visible.
    total = total + 1;
    if (ds_next_data !== 1'b0 || write_ready !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL done_cycle: ready=%b write_ready=%b want 0 1", ds_next_data, write_ready);
    end
    send(fbits(99), 0);
    idle(3);
    total = total + 1;
    if (mem[0][0] !== 32'h42C6_0000) begin
      bad = bad + 1;
      $display("FAIL done_valid_99: got %h want 42c60000", mem[0][0]);
    end
    check_int("done_valid_fin", fin_cnt, exp_fin);
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int f0;
    f0 = fin_cnt;
    for (int k = 0; k < 7; k++) send(fbits(val(1, k)), 0);
    apply_reset();
    idle(3);
    check_int("mid_no_fin", fin_cnt - f0, 0);
    for (int k = 0; k < NE; k++) send(fbits(val(2, k)), 0);
    idle(4);
    check_int("mid_fin", fin_cnt - f0, 1);
    check_int("mid_queue_empty", exp_q.size(), 0);
    check_mem(2, "mid");
  endtask

  initial begin
    rst      = 1'b1;
    ds_valid = 1'b0;
    ds_out   = 32'h0;
    test_reset();
    test_single();
    test_gapped();
    test_two_matrices();
    test_done_valid();
    test_reset_mid();
    check_int("total_fin", fin_cnt, exp_fin);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
